mult_share_arbiter: RTL and testbench
=====================================

# mult_share_arbiter

Time-shares one combinational `dadda_unsigned_multiplier_CLA_32` instance between two independent requesters. It registers the granted operands, holds them stable for a programmable number of settle cycles, then captures the 64-bit product and returns it to the owning requester over a valid/ready response channel. Arbitration is round-robin. The block sits between the multiplier core and the client datapaths, and makes the multiplier a multicycle path.

## Interface
- `SETTLE_CYCLES`, default 2: cycles the operands are held before the product is sampled. Legal range is 1–15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req0_valid` / `req1_valid`  in  1  requester has an operand pair pending.
- `req0_ready` / `req1_ready`  out  1  grant; a transfer occurs when valid && ready.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  32 each  unsigned operands.
- `rsp0_valid` / `rsp1_valid`  out  1  product available for that requester.
- `rsp0_ready` / `rsp1_ready`  in  1  requester consumes the product.
- `rsp_product`  out  64  shared result register, valid only alongside the owner's `rspN_valid`.
- `busy`  out  1  high in CALC or RESP.
- `owner`  out  1  index of the requester currently holding the multiplier.

## Operation
- One internal instance of `dadda_unsigned_multiplier_CLA_32`, driven only from operand registers `a_q` and `b_q` (32 bits each).
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - `reqN_ready` is combinational: it is high only for the requester selected by arbitration, and only when that requester's valid is high.
  - Arbitration:
    - If only one requester is valid, it wins.
    - If both are valid, the winner is the requester that is not `last`.
  - On acceptance:
    - a_q ← reqN_a, b_q ← reqN_b, owner ← N.
    - cnt ← SETTLE_CYCLES−1.
    - Move to CALC.
- **CALC**
  - No ready is asserted.
  - cnt decrements each cycle.
  - On the edge where cnt==0: `rsp_product` ← multiplier output, then move to RESP.
- **RESP**
  - rsp[owner]_valid=1; the other requester's rsp valid stays 0.
  - The response is held stable until rsp[owner]_ready=1.
  - On that edge: last ← owner, then move to IDLE.
  - The other requester's `rspN_ready` is ignored.
- Arithmetic: a full 64-bit unsigned product with no truncation. 0xFFFFFFFF×0xFFFFFFFF = 0xFFFFFFFE00000001.
- Operand inputs are sampled only at acceptance. Changes to `reqN_a` / `reqN_b` afterwards have no effect.
- Reset (any state, asynchronous):
  - Outputs: all readies 0, rsp valids 0, rsp_product 0, busy 0, owner 0.
  - Internal: a_q/b_q/cnt 0, state IDLE, last 1 (requester 0 wins the first tie).
  - An in-flight operation is dropped with no response.

## Timing
- Acceptance edge at cycle k → `rspN_valid` visible after edge k+SETTLE_CYCLES. Example: SETTLE_CYCLES=2 gives a 2-cycle latency.
- Minimum issue interval per operation = SETTLE_CYCLES + 2 cycles (accept, settle, one RESP cycle with ready already high, then back in IDLE).
- No new request is accepted in the same cycle a response is consumed. IDLE is always visited for at least one cycle.
- `busy` is registered: high from the cycle after acceptance through the final RESP cycle.
- Back-to-back contention alternates grants 0,1,0,1. A requester that holds valid continuously is never starved beyond one operation.
- A requester may deassert valid before being granted; no transfer occurs.

## Test plan
- **Reset then single op:** req0 3×5, rsp0_ready=1 → after 2 cycles rsp0_valid=1 and rsp_product=15; rsp1_valid stays 0; busy drops the cycle after.
- **Max operands:** req1 0xFFFFFFFF×0xFFFFFFFF → rsp_product=0xFFFFFFFE00000001 on rsp1_valid.
- **Tie after reset:** both valid, req0 0x27712771×1, req1 2×0x10 → req0 served first (0x27712771), then req1 (0x20); the grant alternates on repeated ties for 6 operations.
- **Backpressure:** rsp0_ready=0 for 5 cycles during RESP → rsp0_valid and rsp_product held constant, req1 not granted; then ready=1 → IDLE, then req1 granted.
- **Operand change after grant:** change req0_a during CALC → product still uses the captured value.
- **Reset mid-CALC:** assert rst → all outputs 0 immediately (asynchronous); after release, no stale rsp_valid; a new op 7×6 returns 42.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin time-sharing of one combinational 32x32 multiplier between two requesters.
// Operands are held in registers for SETTLE_CYCLES cycles, making the multiplier a multicycle path.

module dadda_unsigned_multiplier_CLA_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product
);

    logic [63:0] pp;
    logic [63:0] maj;
    logic [63:0] sum_v;
    logic [63:0] carry_v;
    logic [63:0] half_sum;
    logic [63:0] gen_v;
    logic [63:0] prop_v;

    // Carry-save reduction: each partial product is folded in with a 3:2 compressor row,
    // so no carry ever ripples until the final adder.
    always_comb begin
        sum_v   = '0;
        carry_v = '0;
        maj     = '0;
        pp      = '0;
        for (int i = 0; i < 32; i++) begin
            pp      = b[i] ? ({32'b0, a} << i) : 64'b0;
            maj     = (sum_v & carry_v) | (sum_v & pp) | (carry_v & pp);
            sum_v   = sum_v ^ carry_v ^ pp;
            carry_v = maj << 1;
        end
    end

    // Final carry-lookahead add as a Kogge-Stone prefix tree; descending index order
    // keeps the lower-index operands at their previous-level values within each level.
    always_comb begin
        half_sum = sum_v ^ carry_v;
        gen_v    = sum_v & carry_v;
        prop_v   = half_sum;
        for (int d = 1; d < 64; d = d * 2) begin
            for (int i = 63; i >= d; i--) begin
                gen_v[i]  = gen_v[i] | (prop_v[i] & gen_v[i-d]);
                prop_v[i] = prop_v[i] & prop_v[i-d];
            end
        end
        product = half_sum ^ {gen_v[62:0], 1'b0};
    end

endmodule

module mult_share_arbiter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp_product,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    // Legal SETTLE_CYCLES range is 1..15, so the countdown fits in four bits.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [3:0]  cnt;
    logic        last;
    logic        grant0;
    logic        grant1;
    logic        rsp_taken;
    logic [63:0] mult_product;

    dadda_unsigned_multiplier_CLA_32 u_mult (
        .a       (a_q),
        .b       (b_q),
        .product (mult_product)
    );

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant0    = req0_valid && (!req1_valid || last);
        grant1    = req1_valid && (!req0_valid || !last);
        rsp_taken = owner ? rsp1_ready : rsp0_ready;
    end

    assign req0_ready = (state == IDLE) && !rst && grant0;
    assign req1_ready = (state == IDLE) && !rst && grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt         <= '0;
            last        <= 1'b1;
            owner       <= 1'b0;
            busy        <= 1'b0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp_product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        a_q   <= req0_a;
                        b_q   <= req0_b;
                        owner <= 1'b0;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else if (grant1) begin
                        a_q   <= req1_a;
                        b_q   <= req1_b;
                        owner <= 1'b1;
                        cnt   <= CNT_INIT;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (cnt == 4'd0) begin
                        rsp_product <= mult_product;
                        rsp0_valid  <= !owner;
                        rsp1_valid  <= owner;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_taken) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        last       <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: expected products are queued at acceptance
// and compared when the owning requester consumes the response.

module tb_mult_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [63:0] rsp_product;
    logic [63:0] held;
    logic        busy, owner;
    logic        ok;

    typedef struct {
        logic        owner;
        logic [63:0] product;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mult_share_arbiter #(.SETTLE_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp_product (rsp_product),
        .busy        (busy),
        .owner       (owner)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic popCheck(input logic port, input logic [63:0] prod);
        exp_t e;
        if (exp_q.size() == 0) begin
            checkOutput("sb_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            checkOutput("sb_owner", {63'b0, port}, {63'b0, e.owner});
            checkOutput("sb_product", prod, e.product);
        end
    endtask

    // Sampling on the falling edge: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready)
                exp_q.push_back('{1'b0, {32'b0, req0_a} * {32'b0, req0_b}});
            if (req1_valid && req1_ready)
                exp_q.push_back('{1'b1, {32'b0, req1_a} * {32'b0, req1_b}});
            if (req0_ready && req1_ready)
                checkOutput("grant_exclusive", 64'd1, 64'd0);
            if (rsp0_valid && rsp1_valid)
                checkOutput("rsp_exclusive", 64'd1, 64'd0);
            if (rsp0_valid && rsp0_ready)
                popCheck(1'b0, rsp_product);
            if (rsp1_valid && rsp1_ready)
                popCheck(1'b1, rsp_product);
        end
    end

    task automatic applyStimulus(input logic port, input logic [31:0] a, input logic [31:0] b);
        logic got;
        if (!port) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = port ? req1_ready : req0_ready;
        end
        if (!got) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (!port) req0_valid = 1'b0;
        else       req1_valid = 1'b0;
    endtask

    task automatic waitResponse(input logic port);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = port ? rsp1_valid : rsp0_valid;
        end
        if (!got) checkOutput("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitIdle();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = !busy;
        end
        if (!got) checkOutput("idle_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("rst_ready0", {63'b0, req0_ready}, 64'd0);
        checkOutput("rst_busy", {63'b0, busy}, 64'd0);
        checkOutput("rst_owner", {63'b0, owner}, 64'd0);
        checkOutput("rst_rsp_valid", {62'b0, rsp1_valid, rsp0_valid}, 64'd0);
        checkOutput("rst_product", rsp_product, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        @(posedge clk); #1;

        // Single op with exact latency checks
        applyStimulus(1'b0, 32'd3, 32'd5);
        @(negedge clk);
        checkOutput("lat_busy", {63'b0, busy}, 64'd1);
        checkOutput("lat_k0", {63'b0, rsp0_valid}, 64'd0);
        @(negedge clk);
        checkOutput("lat_k1", {63'b0, rsp0_valid}, 64'd0);
        @(negedge clk);
        checkOutput("lat_k2", {63'b0, rsp0_valid}, 64'd1);
        checkOutput("single_product", rsp_product, 64'd15);
        checkOutput("single_rsp1", {63'b0, rsp1_valid}, 64'd0);
        checkOutput("single_owner", {63'b0, owner}, 64'd0);
        @(negedge clk);
        checkOutput("single_busy_drop", {63'b0, busy}, 64'd0);
        checkOutput("single_rsp_drop", {63'b0, rsp0_valid}, 64'd0);
        @(posedge clk); #1;

        // Max operands
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitResponse(1'b1);
        checkOutput("max_product", rsp_product, 64'hFFFF_FFFE_0000_0001);
        waitIdle();

        // Ties after reset alternate 0,1,0,1...
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h2771_2771; req0_b = 32'd1;
        req1_valid = 1'b1; req1_a = 32'd2;         req1_b = 32'h10;
        for (int op = 0; op < 6; op++) begin
            ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                ok = req0_ready || req1_ready;
            end
            checkOutput("tie_grant", {62'b0, req1_ready, req0_ready}, (op % 2) ? 64'd2 : 64'd1);
            @(posedge clk); #1;
            if (op == 5) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        waitIdle();

        // Backpressure on rsp0 while req1 waits
        rsp0_ready = 1'b0;
        applyStimulus(1'b0, 32'h1234, 32'h5678);
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9;
        waitResponse(1'b0);
        held = rsp_product;
        checkOutput("bp_product", rsp_product, 64'h1234 * 64'h5678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_valid_held", {63'b0, rsp0_valid}, 64'd1);
            checkOutput("bp_product_held", rsp_product, held);
            checkOutput("bp_no_grant1", {63'b0, req1_ready}, 64'd0);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_rsp_released", {63'b0, rsp0_valid}, 64'd0);
        checkOutput("bp_regrant", {63'b0, req1_ready}, 64'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        waitResponse(1'b1);
        checkOutput("bp_req1_product", rsp_product, 64'd81);
        waitIdle();

        // Operand change after grant
        applyStimulus(1'b0, 32'd100, 32'd200);
        req0_a = 32'd999;
        req0_b = 32'd1;
        waitResponse(1'b0);
        checkOutput("operand_hold", rsp_product, 64'd20000);
        waitIdle();

        // Asynchronous reset while req1 is in CALC
        applyStimulus(1'b1, 32'd11, 32'd13);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_busy", {63'b0, busy}, 64'd0);
        checkOutput("arst_owner", {63'b0, owner}, 64'd0);
        checkOutput("arst_product", rsp_product, 64'd0);
        checkOutput("arst_rsp_valid", {62'b0, rsp1_valid, rsp0_valid}, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no_stale_rsp", {62'b0, rsp1_valid, rsp0_valid}, 64'd0);
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'd7, 32'd6);
        waitResponse(1'b0);
        checkOutput("post_reset_product", rsp_product, 64'd42);
        waitIdle();

        // A few random operands through both ports
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i[0], $urandom, $urandom);
            waitResponse(i[0]);
            waitIdle();
        end

        checkOutput("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
